// File: rtl/serv_mtimer_pkg.sv
// serv_mtimer_pkg
//   Shared definitions for the machine-timer peripheral: Wishbone word
//   addresses, the mtimecmp reset value, CTRL field positions and a
//   byte-lane merge helper used by every writable register.
package serv_mtimer_pkg;

    localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
    localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
    localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] ADR_CTRL        = 3'd4;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 8;

    // Replace the bytes of old_word whose select bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = sel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/serv_mtimer_prescaler.sv
// serv_mtimer_prescaler
//   Divides the clock into mtime ticks. The count runs 0..div while enabled
//   and o_tick is high in the cycle the count equals div.
//   Ports:
//     i_clk, i_rst  clock, asynchronous active-high reset
//     en            count enable; when low the count holds and no tick fires
//     div           terminal count (tick period is div+1 cycles)
//     clr           synchronous clear of the count (CTRL write)
//     o_tick        one-cycle tick
module serv_mtimer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  clr,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] count;

    assign o_tick = en & (count == div);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (o_tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/serv_mtimer.sv
// serv_mtimer
//   Machine timer: 64-bit mtime counter advanced by a prescaler, 64-bit
//   mtimecmp, and a registered level interrupt while mtime >= mtimecmp.
//   Ports:
//     i_clk, i_rst      clock, asynchronous active-high reset
//     i_wb_cyc/i_wb_we  Wishbone classic request (cyc doubles as stb), write
//     i_wb_adr          word address: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO,
//                       3 MTIMECMP_HI, 4 CTRL {div[8+:W], en[0]}, 5-7 unmapped
//     i_wb_dat/i_wb_sel write data and byte enables
//     o_wb_dat/o_wb_ack read data and one-cycle acknowledge
//     o_irq             timer interrupt level (to the CSR unit's i_mtip)
//
// Handshake: the master raises i_wb_cyc and holds cyc/we/adr/dat/sel until
// it sees o_wb_ack. Ack is registered one cycle after the request and never
// two cycles in a row. Read data and the hi_shadow capture are registered on
// the edge that raises ack; writes are committed on the edge that ends the
// ack cycle, so written values are visible the cycle after ack.
module serv_mtimer
    import serv_mtimer_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_irq
);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic                  en;
    logic [PRESCALE_W-1:0] div;
    logic [31:0]           hi_shadow;

    logic                  tick;
    logic                  req_stb;
    logic                  wr_stb;
    logic                  wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
    logic [31:0]           ctrl_word;
    logic [31:0]           rd_data;
    logic                  en_next;
    logic [PRESCALE_W-1:0] div_next;

    assign req_stb     = i_wb_cyc & ~o_wb_ack;
    assign wr_stb      = i_wb_cyc & i_wb_we & o_wb_ack;
    assign wr_mtime_lo = wr_stb & (i_wb_adr == ADR_MTIME_LO);
    assign wr_mtime_hi = wr_stb & (i_wb_adr == ADR_MTIME_HI);
    assign wr_cmp_lo   = wr_stb & (i_wb_adr == ADR_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_stb & (i_wb_adr == ADR_MTIMECMP_HI);
    assign wr_ctrl     = wr_stb & (i_wb_adr == ADR_CTRL);

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_EN_BIT] = en;
        ctrl_word[CTRL_DIV_LSB +: PRESCALE_W] = div;
    end

    // Per-bit byte-lane merge of the CTRL fields, so only implemented bits
    // are touched.
    always_comb begin
        en_next  = i_wb_sel[CTRL_EN_BIT/8] ? i_wb_dat[CTRL_EN_BIT] : en;
        div_next = div;
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (i_wb_sel[(CTRL_DIV_LSB+i)/8]) begin
                div_next[i] = i_wb_dat[CTRL_DIV_LSB+i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (i_wb_adr)
            ADR_MTIME_LO:    rd_data = mtime[31:0];
            ADR_MTIME_HI:    rd_data = hi_shadow;
            ADR_MTIMECMP_LO: rd_data = mtimecmp[31:0];
            ADR_MTIMECMP_HI: rd_data = mtimecmp[63:32];
            ADR_CTRL:        rd_data = ctrl_word;
            default:         rd_data = '0;
        endcase
    end

    serv_mtimer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .en     (en),
        .div    (div),
        .clr    (wr_ctrl),
        .o_tick (tick)
    );

    // Bus response. Reading MTIME_LO snapshots the upper half in the same
    // edge so a following MTIME_HI read is consistent with the low word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb_ack  <= 1'b0;
            o_wb_dat  <= '0;
            hi_shadow <= '0;
        end else begin
            o_wb_ack <= req_stb;
            if (req_stb) begin
                o_wb_dat <= i_wb_we ? 32'd0 : rd_data;
                if (!i_wb_we && (i_wb_adr == ADR_MTIME_LO)) begin
                    hi_shadow <= mtime[63:32];
                end
            end
        end
    end

    // A software write wins over a same-cycle tick, and the other half is
    // left untouched (no increment) in that cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], i_wb_dat, i_wb_sel);
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], i_wb_dat, i_wb_sel);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], i_wb_dat, i_wb_sel);
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], i_wb_dat, i_wb_sel);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            en  <= 1'b1;
            div <= '0;
        end else if (wr_ctrl) begin
            en  <= en_next;
            div <= div_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_serv_mtimer.sv
// tb_serv_mtimer
//   Bench for serv_mtimer: a directed register table, hand-written corner
//   sequences and a randomized phase, all scored against a cycle model built
//   from the timer's rules (elapsed enabled cycles, 64-bit arithmetic).
module tb_serv_mtimer;
    import serv_mtimer_pkg::*;

    localparam int PW = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_wb_cyc;
    logic        i_wb_we;
    logic [2:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    serv_mtimer #(.PRESCALE_W(PW)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_we  (i_wb_we),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .o_wb_dat (o_wb_dat),
        .o_wb_ack (o_wb_ack),
        .o_irq    (o_irq)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_mtime, m_cmp;
    logic        m_en;
    logic [PW-1:0] m_div;
    int unsigned m_en_cycles;   // enabled cycles since the last CTRL write / reset
    logic [31:0] m_shadow;
    logic        m_ack, m_ack_rd, m_irq;
    logic        m_tick, m_req, m_wr;
    logic [31:0] m_ctrl, m_merged;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_en = 1'b1; m_div = '0;
            m_en_cycles = 0; m_shadow = 32'd0; m_ack = 1'b0; m_ack_rd = 1'b0; m_irq = 1'b0;
            exp_q.delete();
        end else begin
            // a tick lands on every (div+1)-th enabled cycle
            m_tick = m_en && ((m_en_cycles % (32'(m_div) + 32'd1)) == 32'(m_div));
            m_irq  = (m_mtime >= m_cmp);
            m_req  = i_wb_cyc && !m_ack;
            m_wr   = i_wb_cyc && i_wb_we && m_ack;
            m_ctrl = {16'd0, m_div, 7'd0, m_en};
            if (m_req && !i_wb_we) begin
                case (i_wb_adr)
                    ADR_MTIME_LO:    begin exp_q.push_back(m_mtime[31:0]); m_shadow = m_mtime[63:32]; end
                    ADR_MTIME_HI:    exp_q.push_back(m_shadow);
                    ADR_MTIMECMP_LO: exp_q.push_back(m_cmp[31:0]);
                    ADR_MTIMECMP_HI: exp_q.push_back(m_cmp[63:32]);
                    ADR_CTRL:        exp_q.push_back(m_ctrl);
                    default:         exp_q.push_back(32'd0);
                endcase
            end
            m_ack_rd = m_req && !i_wb_we;
            if (m_wr && i_wb_adr == ADR_MTIME_LO)
                m_mtime[31:0] = merge(m_mtime[31:0], i_wb_dat, i_wb_sel);
            else if (m_wr && i_wb_adr == ADR_MTIME_HI)
                m_mtime[63:32] = merge(m_mtime[63:32], i_wb_dat, i_wb_sel);
            else if (m_tick)
                m_mtime = m_mtime + 64'd1;
            if (m_wr && i_wb_adr == ADR_MTIMECMP_LO) m_cmp[31:0]  = merge(m_cmp[31:0], i_wb_dat, i_wb_sel);
            if (m_wr && i_wb_adr == ADR_MTIMECMP_HI) m_cmp[63:32] = merge(m_cmp[63:32], i_wb_dat, i_wb_sel);
            if (m_wr && i_wb_adr == ADR_CTRL) begin
                m_en_cycles = 0;
                m_merged = merge(m_ctrl, i_wb_dat, i_wb_sel);
                m_en  = m_merged[0];
                m_div = m_merged[15:8];
            end else if (m_en) begin
                m_en_cycles++;
            end
            m_ack = m_req;
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge i_clk) begin
        chk("ack", o_wb_ack, m_ack);
        chk("irq", o_irq, m_irq);
        if (m_ack && m_ack_rd) begin
            if (exp_q.size() == 0) begin
                chk("rdata_noexp", 1'b1, 1'b0);
            end else begin
                chk($sformatf("rdata_adr%0d", i_wb_adr), o_wb_dat, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        repeat (2) @(negedge i_clk);
        #2 i_rst = 1'b0;
    endtask

    task automatic bus(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output logic [31:0] rdata);
        int n;
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_we = we; i_wb_adr = adr; i_wb_sel = sel; i_wb_dat = dat;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_wb_ack && n < 8);
        chk("ack_seen", o_wb_ack, 1'b1);
        rdata = o_wb_dat;
        @(posedge i_clk);
        #1 i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wait_irq(input logic lvl, input int maxc, input string name);
        int n = 0;
        while (o_irq !== lvl && n < maxc) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, o_irq, lvl);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[21];

    // ---------------- test ----------------
    initial begin
        logic [31:0] rd, lo, hi;
        int op;

        tbl[0]  = '{1'b0, ADR_MTIMECMP_HI, 4'hF, 32'h0,        32'hFFFF_FFFF};
        tbl[1]  = '{1'b0, ADR_MTIMECMP_LO, 4'hF, 32'h0,        32'hFFFF_FFFF};
        tbl[2]  = '{1'b0, ADR_CTRL,        4'hF, 32'h0,        32'h0000_0001};
        tbl[3]  = '{1'b0, 3'd5,            4'hF, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 3'd6,            4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[5]  = '{1'b0, 3'd6,            4'hF, 32'h0,        32'h0};
        tbl[6]  = '{1'b0, 3'd7,            4'hF, 32'h0,        32'h0};
        tbl[7]  = '{1'b1, ADR_MTIMECMP_HI, 4'hF, 32'h0,        32'h0};
        tbl[8]  = '{1'b1, ADR_MTIMECMP_LO, 4'hF, 32'h1234_5678, 32'h0};
        tbl[9]  = '{1'b0, ADR_MTIMECMP_LO, 4'hF, 32'h0,        32'h1234_5678};
        tbl[10] = '{1'b1, ADR_MTIMECMP_LO, 4'b0100, 32'h00AB_0000, 32'h0};
        tbl[11] = '{1'b0, ADR_MTIMECMP_LO, 4'hF, 32'h0,        32'h12AB_5678};
        tbl[12] = '{1'b0, ADR_MTIMECMP_HI, 4'hF, 32'h0,        32'h0};
        tbl[13] = '{1'b1, ADR_CTRL,        4'hF, 32'h0000_0301, 32'h0};
        tbl[14] = '{1'b0, ADR_CTRL,        4'hF, 32'h0,        32'h0000_0301};
        tbl[15] = '{1'b1, ADR_CTRL,        4'b0010, 32'h0000_0500, 32'h0};
        tbl[16] = '{1'b0, ADR_CTRL,        4'hF, 32'h0,        32'h0000_0501};
        tbl[17] = '{1'b1, ADR_CTRL,        4'b0001, 32'h0,     32'h0};
        tbl[18] = '{1'b0, ADR_CTRL,        4'hF, 32'h0,        32'h0000_0500};
        tbl[19] = '{1'b1, ADR_CTRL,        4'hF, 32'h0000_0001, 32'h0};
        tbl[20] = '{1'b0, ADR_CTRL,        4'hF, 32'h0,        32'h0000_0001};

        i_rst = 1'b1; i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        i_wb_adr = '0; i_wb_sel = '0; i_wb_dat = '0;
        repeat (3) @(negedge i_clk);
        #2 i_rst = 1'b0;

        // idle count with div=0, then the register table
        repeat (10) @(negedge i_clk);
        bus(1'b0, ADR_MTIME_LO, 4'hF, 32'h0, rd);
        for (int i = 0; i < 21; i++) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd);
            if (!tbl[i].we) chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end

        // interrupt at mtimecmp = 20, then cleared by raising mtimecmp
        do_reset();
        bus(1'b1, ADR_MTIMECMP_HI, 4'hF, 32'd0, rd);
        bus(1'b1, ADR_MTIMECMP_LO, 4'hF, 32'd20, rd);
        wait_irq(1'b1, 100, "irq_rise");
        repeat (5) @(negedge i_clk);
        chk("irq_held", o_irq, 1'b1);
        bus(1'b1, ADR_MTIMECMP_LO, 4'hF, 32'd1000, rd);
        @(negedge i_clk);
        chk("irq_after_update", o_irq, 1'b1);
        @(negedge i_clk);
        chk("irq_cleared", o_irq, 1'b0);

        // div=3, freeze with en=0, resume
        bus(1'b1, ADR_CTRL, 4'hF, 32'h0000_0301, rd);
        repeat (20) @(negedge i_clk);
        bus(1'b0, ADR_MTIME_LO, 4'hF, 32'h0, rd);
        bus(1'b1, ADR_CTRL, 4'hF, 32'h0000_0300, rd);
        bus(1'b0, ADR_MTIME_LO, 4'hF, 32'h0, lo);
        repeat (50) @(negedge i_clk);
        bus(1'b0, ADR_MTIME_LO, 4'hF, 32'h0, rd);
        chk("frozen", rd, lo);
        bus(1'b1, ADR_CTRL, 4'hF, 32'h0000_0301, rd);
        repeat (13) @(negedge i_clk);
        bus(1'b0, ADR_MTIME_LO, 4'hF, 32'h0, rd);

        // carry between halves read as LO then HI
        for (int k = 0; k < 2; k++) begin
            bus(1'b1, ADR_CTRL, 4'hF, (k == 0) ? 32'h0000_0001 : 32'h0000_0F01, rd);
            bus(1'b1, ADR_MTIME_HI, 4'hF, 32'h0, rd);
            bus(1'b1, ADR_MTIME_LO, 4'hF, 32'hFFFF_FFFF, rd);
            bus(1'b0, ADR_MTIME_LO, 4'hF, 32'h0, lo);
            bus(1'b0, ADR_MTIME_HI, 4'hF, 32'h0, hi);
            chk($sformatf("carry_hi%0d", k), hi, (lo == 32'hFFFF_FFFF) ? 32'd0 : 32'd1);
        end

        // wrap from all ones with mtimecmp = 5
        bus(1'b1, ADR_CTRL, 4'hF, 32'h0000_0001, rd);
        bus(1'b1, ADR_MTIMECMP_HI, 4'hF, 32'd0, rd);
        bus(1'b1, ADR_MTIMECMP_LO, 4'hF, 32'd5, rd);
        bus(1'b1, ADR_MTIME_HI, 4'hF, 32'hFFFF_FFFF, rd);
        bus(1'b1, ADR_MTIME_LO, 4'hF, 32'hFFFF_FFF8, rd);
        wait_irq(1'b1, 10, "irq_allones");
        wait_irq(1'b0, 20, "irq_wrap_clear");
        wait_irq(1'b1, 20, "irq_after_wrap");
        bus(1'b1, ADR_MTIME_LO, 4'hF, 32'h0000_0055, rd);
        bus(1'b0, ADR_MTIME_LO, 4'hF, 32'h0, rd);

        // reset in the middle of an access, then an unmapped access
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = ADR_MTIME_LO; i_wb_sel = 4'hF;
        @(posedge i_clk);
        #1 chk("midacc_ack", o_wb_ack, 1'b1);
        i_rst = 1'b1;
        #1 chk("rst_ack_drop", o_wb_ack, 1'b0);
        chk("rst_dat", o_wb_dat, 32'd0);
        chk("rst_irq", o_irq, 1'b0);
        i_wb_cyc = 1'b0;
        repeat (2) @(negedge i_clk);
        #2 i_rst = 1'b0;
        bus(1'b0, ADR_MTIMECMP_HI, 4'hF, 32'h0, rd);
        chk("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        bus(1'b0, ADR_CTRL, 4'hF, 32'h0, rd);
        chk("rst_ctrl", rd, 32'h0000_0001);
        bus(1'b0, 3'd6, 4'hF, 32'h0, rd);
        chk("unmapped6", rd, 32'd0);

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: bus(1'b0, 3'($urandom_range(0, 7)), 4'hF, 32'h0, rd);
                4: bus(1'b1, ADR_MTIMECMP_LO, 4'($urandom_range(0, 15)),
                       m_mtime[31:0] + 32'($urandom_range(0, 40)), rd);
                5: bus(1'b1, ADR_MTIMECMP_HI, 4'hF, m_mtime[63:32] + 32'($urandom_range(0, 1)), rd);
                6: bus(1'b1, ADR_CTRL, 4'($urandom_range(0, 15)),
                       {16'd0, 8'($urandom_range(0, 3)), 7'd0, 1'($urandom_range(0, 3) != 0)}, rd);
                7: bus(1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom, rd);
                8: bus(1'b1, ADR_MTIME_HI, 4'hF, 32'($urandom_range(0, 2)), rd);
                default: repeat ($urandom_range(0, 10)) @(negedge i_clk);
            endcase
        end

        repeat (3) @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serv_mtimer.md
# serv_mtimer

Machine-timer peripheral that drives the core's timer-interrupt-pending input (`i_mtip`) of the CSR unit. It holds a free-running 64-bit `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp` compare register, both accessed over a 32-bit Wishbone classic slave port. It asserts a level interrupt while `mtime >= mtimecmp`. The CSR unit masks this level and edge-detects it into a trap.

## Interface

- `PRESCALE_W`, default 8: width of the prescaler divider field and counter.
- `i_clk` input 1: clock.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_wb_cyc` input 1: Wishbone cycle/strobe (single-signal request).
- `i_wb_we` input 1: write enable.
- `i_wb_adr` input 3: word address (byte address bits [4:2]).
- `i_wb_dat` input 32: write data.
- `i_wb_sel` input 4: byte enables.
- `o_wb_dat` output 32: read data, valid when `o_wb_ack` is high.
- `o_wb_ack` output 1: one-cycle acknowledge.
- `o_irq` output 1: timer interrupt level; connects to `i_mtip`.

## Operation

- Register map (word address):
  - 0 `MTIME_LO`
  - 1 `MTIME_HI`
  - 2 `MTIMECMP_LO`
  - 3 `MTIMECMP_HI`
  - 4 `CTRL`: bit0 `en`; bits [8+PRESCALE_W-1:8] `div`.
  - 5–7: unmapped. Reads return 0, writes are ignored, the access is still acked.
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `en` = 1, `div` = 0.
  - Prescaler count = 0, `hi_shadow` = 0.
  - `o_irq` = 0, `o_wb_ack` = 0, `o_wb_dat` = 0.
- Prescaler:
  - While `en`=1, the count runs 0..`div`.
  - A tick occurs in the cycle the count equals `div`; the count then returns to 0.
  - `div`=0 gives a tick every cycle. `div`=N gives a tick every N+1 cycles.
  - While `en`=0, the count holds and no ticks occur.
  - Any write to `CTRL` clears the count.
- `mtime`:
  - Increments by 1 on each tick, unsigned 64-bit.
  - Wraps from 2^64-1 to 0 with no flag.
- Atomic 64-bit read:
  - A read of `MTIME_LO` returns `mtime[31:0]` and, in the same cycle, captures `mtime[63:32]` into `hi_shadow`.
  - A read of `MTIME_HI` returns `hi_shadow`.
  - Software reads LO first, then HI.
- Writes:
  - Byte-granular per `i_wb_sel`.
  - A write to `MTIME_LO` or `MTIME_HI` overrides a same-cycle tick: the written value is stored and no increment happens that cycle.
  - The unwritten half of `mtime` keeps its value and is not incremented that cycle.
- Interrupt:
  - `o_irq` is a register of `(mtime >= mtimecmp)`, unsigned 64-bit compare of the current register values.
  - It is independent of `en` and is a level signal, not sticky.
  - It clears only when `mtimecmp` is raised above `mtime`, or `mtime` is written or wraps below `mtimecmp`.

## Timing

- Ack:
  - `o_wb_ack` <= `i_wb_cyc & !o_wb_ack`.
  - Ack occurs exactly one cycle after the `i_wb_cyc` rising edge.
  - A held `cyc` produces ack on alternate cycles.
- Register update point:
  - Write side effects take effect in the ack cycle; the updated registers are visible the following cycle.
  - Read data and the `hi_shadow` capture are registered in the same edge that raises ack.
- Interrupt latency:
  - `o_irq` rises 1 cycle after the edge on which `mtime` becomes >= `mtimecmp`.
  - After a `mtimecmp` write, `o_irq` updates 1 cycle after the register update (2 cycles after the ack edge).
- Reset mid-transaction:
  - Ack is dropped immediately.
  - All state returns to reset values; the master must reissue the access.

## Structure

- Shared package `serv_mtimer_pkg` holds:
  - Word-address constants `ADR_MTIME_LO` … `ADR_CTRL`.
  - `MTIMECMP_RST` (all ones).
  - `CTRL_EN_BIT`, `CTRL_DIV_LSB`.
- One sub-module, `serv_mtimer_prescaler` (`PRESCALE_W`):
  - Inputs: `i_clk`, `i_rst`, `en`, `div`, `clr`.
  - Output: one-cycle `o_tick`.
- The top level holds:
  - `mtime`, `mtimecmp`, `CTRL` and `hi_shadow`.
  - Wishbone decode and byte-lane merge.
  - The comparator and the `o_irq` register.

## Test plan

- Reset, then idle 10 cycles with `div`=0:
  - `mtime` reads 10 (±1 for access latency).
  - `o_irq`=0 throughout.
  - Read `MTIMECMP_HI` = FFFF_FFFF.
- Write `mtimecmp` = 20 (HI=0 first, then LO=20):
  - `o_irq` rises exactly one cycle after `mtime` reaches 20 and stays high.
  - Writing `MTIMECMP_LO` = 1000 drops `o_irq` 2 cycles after the ack edge.
- `CTRL` `div`=3:
  - `mtime` increments once every 4 cycles.
  - With `en`=0, `mtime` is frozen for 50 cycles; re-enable and counting resumes from a cleared prescaler.
- Write `mtime` = 0000_0000_FFFF_FFFF, then read LO followed by HI during the carry:
  - HI is consistent with the LO snapshot (LO=FFFF_FFFF → HI=0; LO small → HI=1).
- Write `mtime` = all ones with `mtimecmp` = 5:
  - `o_irq`=1.
  - After the wrap `mtime`=0 and `o_irq`=0 the next cycle.
  - A same-cycle write plus tick stores the written value.
- Byte write `sel`=4'b0100 of 0x00AB0000 to `MTIMECMP_LO`:
  - Only bits [23:16] change.
- Assert `i_rst` mid-access and access an unmapped address:
  - Reset mid-access: ack is cleared and all reset values return.
  - Unmapped address 6: acked, reads 0.
